imm_decode_stage: RTL and testbench

Registered, parametrised immediate-decode stage for the RV core's ID pipeline. It accepts a 32-bit instruction word with a tag on a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN width, plus a format code and an illegal-opcode flag, one cycle later. A 2-entry skid buffer gives full throughput under backpressure, and a synchronous flush supports branch redirects.

---
 rtl/imm_decode_stage.sv | 206 ++++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decodes the RV immediate, format code and
// illegal-opcode flag from a raw instruction word and presents them from flops.
// A main register (M) plus a skid register (K) give full throughput under
// backpressure while keeping in_ready purely registered.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_SH   = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG_32 = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  // Sign-extends a 32-bit signed immediate to XLEN (identity when XLEN=32).
  function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // Zero-extends a shift amount / CSR uimm field to XLEN.
  function automatic logic [XLEN-1:0] zext(input logic [5:0] v);
    return XLEN'(v);
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [2:0] f3;
    logic       s;
    f3        = instr[14:12];
    s         = instr[31];
    d.imm     = '0;
    d.fmt     = FMT_NONE;
    d.illegal = 1'b0;
    case (instr[6:0])
      OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // instr[30] selects arithmetic shift and never belongs to shamt
          d.fmt = FMT_SH;
          d.imm = (XLEN == 64) ? zext(instr[25:20]) : zext({1'b0, instr[24:20]});
        end else begin
          d.fmt = FMT_I;
          d.imm = sext({{20{s}}, instr[31:20]});
        end
      end
      OP_IMM_32: begin
        if (XLEN != 64) begin
          d.illegal = 1'b1;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
          d.fmt = FMT_SH;
          d.imm = zext({1'b0, instr[24:20]});
        end else begin
          d.fmt = FMT_I;
          d.imm = sext({{20{s}}, instr[31:20]});
        end
      end
      OP_LOAD, OP_JALR: begin
        d.fmt = FMT_I;
        d.imm = sext({{20{s}}, instr[31:20]});
      end
      OP_STORE: begin
        d.fmt = FMT_S;
        d.imm = sext({{20{s}}, instr[31:25], instr[11:7]});
      end
      OP_BRANCH: begin
        d.fmt = FMT_B;
        d.imm = sext({{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
      end
      OP_LUI, OP_AUIPC: begin
        d.fmt = FMT_U;
        d.imm = sext({instr[31:12], 12'b0});
      end
      OP_JAL: begin
        d.fmt = FMT_J;
        d.imm = sext({{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
      end
      OP_SYSTEM: begin
        if (f3[2]) begin
          d.fmt = FMT_Z;
          d.imm = zext({1'b0, instr[19:15]});
        end
      end
      OP_REG, OP_FENCE: begin
        d.fmt = FMT_NONE;
      end
      OP_REG_32: begin
        d.illegal = (XLEN != 64);
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  state_t           state_q, state_d;
  logic             accept, drain, ld_m, ld_k, m_from_k;
  logic             vld_p1;
  dec_t             dec_p0;
  dec_t             m_dec_p1, k_dec_p1;
  logic [TAG_W-1:0] m_tag_p1, k_tag_p1;

  assign vld_p1    = (state_q != EMPTY);
  assign out_valid = vld_p1;
  assign in_ready  = (state_q != FULL);
  assign accept    = in_valid && in_ready;
  assign drain     = vld_p1 && out_ready;

  // ---- stage p0: combinational decode of the incoming word ----
  always_comb dec_p0 = decode(in_instr);

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state and load steering; flush overrides every other event.
  always_comb begin
    state_d  = state_q;
    ld_m     = 1'b0;
    ld_k     = 1'b0;
    m_from_k = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin state_d = ONE; ld_m = 1'b1; end
        ONE: begin
          if (accept && drain)  ld_m = 1'b1;
          else if (accept)      begin state_d = FULL; ld_k = 1'b1; end
          else if (drain)       state_d = EMPTY;
        end
        FULL: if (drain) begin state_d = ONE; m_from_k = 1'b1; end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---- stage p1: main output register, reset so outputs start at zero ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dec_p1 <= '0;
      m_tag_p1 <= '0;
    end else if (ld_m) begin
      m_dec_p1 <= dec_p0;
      m_tag_p1 <= in_tag;
    end else if (m_from_k) begin
      m_dec_p1 <= k_dec_p1;
      m_tag_p1 <= k_tag_p1;
    end
  end

  // Skid register payload; its contents only matter while state is FULL.
  always_ff @(posedge clk) begin
    if (ld_k) begin
      k_dec_p1 <= dec_p0;
      k_tag_p1 <= in_tag;
    end
  end

  assign out_imm     = m_dec_p1.imm;
  assign out_fmt     = m_dec_p1.fmt;
  assign out_illegal = m_dec_p1.illegal;
  assign out_tag     = m_tag_p1;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share the same
// stimulus; a decode table is streamed through, then handshake, flush and
// asynchronous-reset sequences are exercised by hand.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [4:0]  in_tag = '0;

  logic        r32_in_ready, r32_out_valid, r32_ill;
  logic [31:0] r32_imm;
  logic [2:0]  r32_fmt;
  logic [4:0]  r32_tag;
  logic        r64_in_ready, r64_out_valid, r64_ill;
  logic [63:0] r64_imm;
  logic [2:0]  r64_fmt;
  logic [4:0]  r64_tag;

  imm_decode_stage #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r32_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(r32_out_valid), .out_ready(out_ready), .out_imm(r32_imm),
    .out_fmt(r32_fmt), .out_illegal(r32_ill), .out_tag(r32_tag)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(r64_out_valid), .out_ready(out_ready), .out_imm(r64_imm),
    .out_fmt(r64_fmt), .out_illegal(r64_ill), .out_tag(r64_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_both(input string name, input logic v, input logic [4:0] tag,
                          input logic [31:0] i32, input logic [2:0] f32, input logic l32,
                          input logic [63:0] i64, input logic [2:0] f64, input logic l64);
    chk({name, ".v32"},   {63'd0, r32_out_valid}, {63'd0, v});
    chk({name, ".v64"},   {63'd0, r64_out_valid}, {63'd0, v});
    chk({name, ".tag32"}, {59'd0, r32_tag}, {59'd0, tag});
    chk({name, ".tag64"}, {59'd0, r64_tag}, {59'd0, tag});
    chk({name, ".imm32"}, {32'd0, r32_imm}, {32'd0, i32});
    chk({name, ".fmt32"}, {61'd0, r32_fmt}, {61'd0, f32});
    chk({name, ".ill32"}, {63'd0, r32_ill}, {63'd0, l32});
    chk({name, ".imm64"}, r64_imm, i64);
    chk({name, ".fmt64"}, {61'd0, r64_fmt}, {61'd0, f64});
    chk({name, ".ill64"}, {63'd0, r64_ill}, {63'd0, l64});
  endtask

  task automatic chk_ctl(input string name, input logic v, input logic rdy);
    chk({name, ".v32"},   {63'd0, r32_out_valid}, {63'd0, v});
    chk({name, ".v64"},   {63'd0, r64_out_valid}, {63'd0, v});
    chk({name, ".rdy32"}, {63'd0, r32_in_ready},  {63'd0, rdy});
    chk({name, ".rdy64"}, {63'd0, r64_in_ready},  {63'd0, rdy});
  endtask

  task automatic chk_tag(input string name, input logic [4:0] tag);
    chk({name, ".tag32"}, {59'd0, r32_tag}, {59'd0, tag});
    chk({name, ".tag64"}, {59'd0, r64_tag}, {59'd0, tag});
  endtask

  initial begin
    //          instr          imm32         f  il  imm64                   f  il
    tv.push_back('{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0});
    tv.push_back('{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0});
    tv.push_back('{32'h00309093, 32'h00000003, 3'd7, 1'b0, 64'h3,                3'd7, 1'b0});
    tv.push_back('{32'h4030D093, 32'h00000003, 3'd7, 1'b0, 64'h3,                3'd7, 1'b0});
    tv.push_back('{32'h3002D073, 32'h00000005, 3'd6, 1'b0, 64'h5,                3'd6, 1'b0});
    tv.push_back('{32'h30029073, 32'h00000000, 3'd0, 1'b0, 64'h0,                3'd0, 1'b0});
    tv.push_back('{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0,                3'd0, 1'b1});
    tv.push_back('{32'h0010009B, 32'h00000000, 3'd0, 1'b1, 64'h1,                3'd1, 1'b0});
    tv.push_back('{32'h02009093, 32'h00000000, 3'd7, 1'b0, 64'h20,               3'd7, 1'b0});
    tv.push_back('{32'h4220D09B, 32'h00000000, 3'd0, 1'b1, 64'h2,                3'd7, 1'b0});
    tv.push_back('{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0});
    tv.push_back('{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0});
    tv.push_back('{32'h12345097, 32'h12345000, 3'd4, 1'b0, 64'h12345000,         3'd4, 1'b0});
    tv.push_back('{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0});
    tv.push_back('{32'h002080B3, 32'h00000000, 3'd0, 1'b0, 64'h0,                3'd0, 1'b0});
    tv.push_back('{32'h002080BB, 32'h00000000, 3'd0, 1'b1, 64'h0,                3'd0, 1'b0});
    tv.push_back('{32'h0FF0000F, 32'h00000000, 3'd0, 1'b0, 64'h0,                3'd0, 1'b0});
    tv.push_back('{32'h80002083, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0});
    tv.push_back('{32'h00000073, 32'h00000000, 3'd0, 1'b0, 64'h0,                3'd0, 1'b0});

    // Reset state
    repeat (2) @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b1);
    chk_both("reset", 1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 64'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back decode stream with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      in_valid = 1'b1;
      in_instr = tv[i].instr;
      in_tag   = 5'(i + 1);
      @(negedge clk);
      chk_ctl($sformatf("vec%0d", i), 1'b1, 1'b1);
      chk_both($sformatf("vec%0d", i), 1'b1, 5'(i + 1), tv[i].imm32, tv[i].fmt32,
               tv[i].ill32, tv[i].imm64, tv[i].fmt64, tv[i].ill64);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk_ctl("drained", 1'b0, 1'b1);

    // Backpressure: tags 1,2 accepted, tag 3 waits, then FIFO drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    in_tag    = 5'd1;
    @(negedge clk);
    chk_ctl("bp1", 1'b1, 1'b1);
    chk_tag("bp1", 5'd1);
    in_tag = 5'd2;
    @(negedge clk);
    chk_ctl("bp2", 1'b1, 1'b0);
    chk_tag("bp2", 5'd1);
    in_tag = 5'd3;
    @(negedge clk);
    chk_ctl("bp3", 1'b1, 1'b0);
    chk_both("bp3_hold", 1'b1, 5'd1, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk_ctl("bp_rel2", 1'b1, 1'b1);
    chk_tag("bp_rel2", 5'd2);
    @(negedge clk);
    in_valid = 1'b0;
    chk_ctl("bp_rel3", 1'b1, 1'b1);
    chk_tag("bp_rel3", 5'd3);
    @(negedge clk);
    chk_ctl("bp_end", 1'b0, 1'b1);

    // Flush while FULL with input offered: nothing survives
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 5'd4;
    @(negedge clk);
    in_tag = 5'd5;
    @(negedge clk);
    chk_ctl("fl_full", 1'b1, 1'b0);
    in_tag = 5'd6;
    flush  = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_ctl("fl_after", 1'b0, 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_ctl($sformatf("fl_quiet%0d", c), 1'b0, 1'b1);
    end

    // Flush while ONE with an input that would otherwise be accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 5'd8;
    @(negedge clk);
    in_tag = 5'd9;
    flush  = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_ctl("fl_one", 1'b0, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk_ctl("fl_one_quiet", 1'b0, 1'b1);

    // First accept after a flush behaves normally
    in_valid = 1'b1;
    in_instr = 32'h00309093;
    in_tag   = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk_both("post_flush", 1'b1, 5'd7, 32'd3, 3'd7, 1'b0, 64'd3, 3'd7, 1'b0);

    // Asynchronous reset mid-stream while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0000007F;
    in_tag    = 5'd10;
    @(negedge clk);
    in_tag = 5'd11;
    @(negedge clk);
    in_valid = 1'b0;
    chk_ctl("ar_full", 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("ar_async", 1'b0, 1'b1);
    chk_both("ar_async", 1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 64'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'hFE000EE3;
    in_tag    = 5'd12;
    @(negedge clk);
    in_valid = 1'b0;
    chk_both("ar_first", 1'b1, 5'd12, 32'hFFFFFFFC, 3'd3, 1'b0,
             64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
    @(negedge clk);
    chk_ctl("ar_done", 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
